// File: rtl/cnn_layer_accel_weight_seq_table_prog.sv
// Run-time programmable weight-address sequencer: one address sequence per Gray-coded
// convolution phase, streamed one registered entry per non-stalled cycle on start.
module cnn_layer_accel_weight_seq_table_prog #(
    parameter int C_NUM_PHASES     = 4,
    parameter int C_SEQ_DEPTH      = 8,
    parameter int C_WHT_ADDR_WIDTH = 4,
    localparam int C_PHASE_W = $clog2(C_NUM_PHASES),
    localparam int C_IDX_W   = $clog2(C_SEQ_DEPTH),
    localparam int C_LEN_W   = $clog2(C_SEQ_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_wr_en,
    input  logic                        cfg_len_wr,
    input  logic [C_PHASE_W-1:0]        cfg_phase,
    input  logic [C_IDX_W-1:0]          cfg_idx,
    input  logic [C_WHT_ADDR_WIDTH-1:0] cfg_data,
    input  logic [C_LEN_W-1:0]          cfg_len,
    output logic                        cfg_err,
    input  logic                        start,
    input  logic [C_PHASE_W-1:0]        gray_code,
    input  logic                        stall,
    output logic [C_WHT_ADDR_WIDTH-1:0] wht_data_addr,
    output logic                        wht_addr_valid,
    output logic                        wht_addr_last,
    output logic                        busy
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [C_IDX_W-1:0]          idx;
    logic [C_IDX_W-1:0]          idx_next;
    logic [C_PHASE_W-1:0]        phase;
    logic [C_PHASE_W-1:0]        phase_next;
    logic [C_PHASE_W-1:0]        start_phase;
    logic [C_WHT_ADDR_WIDTH-1:0] addr_next;
    logic                        valid_next;
    logic                        last_next;

    logic [C_WHT_ADDR_WIDTH-1:0] seq_tbl [C_NUM_PHASES][C_SEQ_DEPTH];
    logic [C_LEN_W-1:0]          len_tbl [C_NUM_PHASES];

    logic [C_LEN_W-1:0]          run_len_m1;
    logic                        run_last;
    logic                        start_last;
    logic                        idx_legal;
    logic                        len_legal;
    logic                        wr_ok;
    logic                        len_ok;
    logic                        cfg_err_next;

    function automatic logic [C_PHASE_W-1:0] gray2bin(input logic [C_PHASE_W-1:0] g);
        logic [C_PHASE_W-1:0] b;
        b[C_PHASE_W-1] = g[C_PHASE_W-1];
        for (int i = C_PHASE_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign start_phase = gray2bin(gray_code);
    assign busy        = (state == RUN);
    assign run_len_m1  = len_tbl[phase] - C_LEN_W'(1);
    assign run_last    = (C_LEN_W'(idx) == run_len_m1);
    assign start_last  = (len_tbl[start_phase] == C_LEN_W'(1));

    // Config writes are only legal between sequences; anything else is dropped and flagged.
    assign idx_legal    = ({1'b0, cfg_idx} < (C_IDX_W + 1)'(C_SEQ_DEPTH));
    assign len_legal    = (cfg_len != '0) && (cfg_len <= C_LEN_W'(C_SEQ_DEPTH));
    assign wr_ok        = cfg_wr_en && !busy && idx_legal;
    assign len_ok       = cfg_len_wr && !busy && len_legal;
    assign cfg_err_next = (cfg_wr_en && !wr_ok) || (cfg_len_wr && !len_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            phase          <= '0;
            wht_data_addr  <= '0;
            wht_addr_valid <= 1'b0;
            wht_addr_last  <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            phase          <= phase_next;
            wht_data_addr  <= addr_next;
            wht_addr_valid <= valid_next;
            wht_addr_last  <= last_next;
            cfg_err        <= cfg_err_next;
        end
    end

    // Stall freezes everything by leaving the defaults (current values) in place.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        phase_next = phase;
        addr_next  = wht_data_addr;
        valid_next = wht_addr_valid;
        last_next  = wht_addr_last;

        if (!stall) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        phase_next = start_phase;
                        addr_next  = seq_tbl[start_phase][0];
                        valid_next = 1'b1;
                        last_next  = start_last;
                        if (!start_last) begin
                            state_next = RUN;
                            idx_next   = C_IDX_W'(1);
                        end else begin
                            idx_next   = '0;
                        end
                    end else begin
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                    end
                end
                RUN: begin
                    addr_next  = seq_tbl[phase][idx];
                    valid_next = 1'b1;
                    last_next  = run_last;
                    if (run_last) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next   = idx + C_IDX_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Reads above see the pre-write contents, so a write coinciding with start lands next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < C_NUM_PHASES; p++) begin
                for (int i = 0; i < C_SEQ_DEPTH; i++) begin
                    seq_tbl[p][i] <= C_WHT_ADDR_WIDTH'(i);
                end
                len_tbl[p] <= C_LEN_W'(C_SEQ_DEPTH);
            end
        end else begin
            if (wr_ok) begin
                seq_tbl[cfg_phase][cfg_idx] <= cfg_data;
            end
            if (len_ok) begin
                len_tbl[cfg_phase] <= cfg_len;
            end
        end
    end

endmodule
